// File: rtl/hazard_stall_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_stall_ctrl
//
// Pipeline sequencer for the PC, IF/ID and ID/EX pipeline registers.
// - Load-use hazard: inserts one bubble into ID/EX and holds PC and IF/ID.
// - Taken branch resolved in EX: flushes IF/ID and bubbles ID/EX.
// - Multi-cycle multiply: holds the front end and EX while it occupies EX.
// - Counts cycles where the PC is held (stall_cnt).
//
// Handshake note: this block has no valid/ready channels. All outputs are
// combinational from the current state and the current inputs. Enables are
// sampled by the pipeline registers on the same rising clk edge that
// updates this block's state.
//
// Ports
//   clk, rst_n        clock (rising edge), async active-low reset
//   id_*              ID-stage instruction: valid, sources, source usage, mul
//   ex_rd/ex_is_load  EX-stage destination register and load flag
//   branch_taken      EX branch resolved taken this cycle
//   cnt_clr           synchronous clear of stall_cnt
//   pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_bubble  pipeline controls
//   mul_busy          FSM state indicator (1 = MUL_BUSY)
//   stall_cnt         cycles with pc_en=0, wraps modulo 2^CNT_W
// ---------------------------------------------------------------------------
module hazard_stall_ctrl #(
    parameter int MUL_LAT = 4,
    parameter int REG_W   = 5,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic             id_is_mul,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_is_load,
    input  logic             branch_taken,
    input  logic             cnt_clr,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             if_id_flush,
    output logic             id_ex_en,
    output logic             id_ex_bubble,
    output logic             mul_busy,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic {
        ST_RUN      = 1'b0,
        ST_MUL_BUSY = 1'b1
    } state_e;

    // The cycle the multiply is accepted counts as its first EX cycle, so
    // MUL_LAT-1 further hold cycles remain.
    localparam logic [3:0] MUL_INIT = 4'(MUL_LAT - 1);
    localparam bit         MUL_HOLD = (MUL_LAT > 1);

    state_e           state_q, state_d;
    logic [3:0]       mul_cnt_q, mul_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic lu_haz;
    logic rs1_hit, rs2_hit;
    logic mul_start;

    // Load into x0 never creates a dependency.
    assign rs1_hit   = id_use_rs1 && (id_rs1 == ex_rd);
    assign rs2_hit   = id_use_rs2 && (id_rs2 == ex_rd);
    assign lu_haz    = id_valid && ex_is_load && (ex_rd != '0) && (rs1_hit || rs2_hit);
    assign mul_start = MUL_HOLD && id_valid && id_is_mul && !branch_taken && !lu_haz;

    // State register and counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            mul_cnt_q   <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            mul_cnt_q   <= mul_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d   = state_q;
        mul_cnt_d = mul_cnt_q;
        case (state_q)
            ST_RUN: begin
                if (mul_start) begin
                    state_d   = ST_MUL_BUSY;
                    mul_cnt_d = MUL_INIT;
                end
            end
            ST_MUL_BUSY: begin
                mul_cnt_d = mul_cnt_q - 4'd1;
                if (mul_cnt_q == 4'd1) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d   = ST_RUN;
                mul_cnt_d = '0;
            end
        endcase
    end

    // Output logic
    always_comb begin
        pc_en        = 1'b1;
        if_id_en     = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_en     = 1'b1;
        id_ex_bubble = 1'b0;
        mul_busy     = 1'b0;
        if (!rst_n) begin
            // Pipeline registers see NOPs and nothing advances during reset.
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_en     = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
        end else if (state_q == ST_MUL_BUSY) begin
            pc_en    = 1'b0;
            if_id_en = 1'b0;
            id_ex_en = 1'b0;
            mul_busy = 1'b1;
        end else if (branch_taken) begin
            // Flush wins: the hazarding instruction is on the wrong path.
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
        end else if (lu_haz) begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_bubble = 1'b1;
        end
    end

    // Stall counter; clear wins over a simultaneous increment.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (cnt_clr) begin
            stall_cnt_d = '0;
        end else if (!pc_en) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hazard_stall_ctrl
//
// Drives directed scenarios followed by random traffic. For every cycle the
// driver computes the expected outputs from a behavioural model (remaining
// multiply hold cycles, stall count as an integer modulo 2^CNT_W) and pushes
// them into exp_q; the monitor pops and compares on the falling edge.
// ---------------------------------------------------------------------------
module tb_hazard_stall_ctrl;

    localparam int MUL_LAT = 4;
    localparam int REG_W   = 5;
    localparam int CNT_W   = 4;
    localparam int W       = 6 + CNT_W;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst_n = 1'b0;
    logic             id_valid = 1'b0;
    logic [REG_W-1:0] id_rs1 = '0;
    logic [REG_W-1:0] id_rs2 = '0;
    logic             id_use_rs1 = 1'b0;
    logic             id_use_rs2 = 1'b0;
    logic             id_is_mul = 1'b0;
    logic [REG_W-1:0] ex_rd = '0;
    logic             ex_is_load = 1'b0;
    logic             branch_taken = 1'b0;
    logic             cnt_clr = 1'b0;
    logic             pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_bubble, mul_busy;
    logic [CNT_W-1:0] stall_cnt;

    hazard_stall_ctrl #(
        .MUL_LAT(MUL_LAT),
        .REG_W  (REG_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .id_valid    (id_valid),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_use_rs1  (id_use_rs1),
        .id_use_rs2  (id_use_rs2),
        .id_is_mul   (id_is_mul),
        .ex_rd       (ex_rd),
        .ex_is_load  (ex_is_load),
        .branch_taken(branch_taken),
        .cnt_clr     (cnt_clr),
        .pc_en       (pc_en),
        .if_id_en    (if_id_en),
        .if_id_flush (if_id_flush),
        .id_ex_en    (id_ex_en),
        .id_ex_bubble(id_ex_bubble),
        .mul_busy    (mul_busy),
        .stall_cnt   (stall_cnt)
    );

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    // Reference model state
    int m_hold  = 0;  // multiply hold cycles still to come
    int m_stall = 0;  // stall count modulo 2^CNT_W

    task automatic drive(input bit rst, input bit vld, input int rs1, input int rs2,
                         input bit u1, input bit u2, input bit mul, input int rd,
                         input bit ld, input bit br, input bit clr);
        bit lu, p, ie, fl, ee, bb, busy;
        @(posedge clk);
        #1;
        rst_n        = rst;
        id_valid     = vld;
        id_rs1       = REG_W'(rs1);
        id_rs2       = REG_W'(rs2);
        id_use_rs1   = u1;
        id_use_rs2   = u2;
        id_is_mul    = mul;
        ex_rd        = REG_W'(rd);
        ex_is_load   = ld;
        branch_taken = br;
        cnt_clr      = clr;

        // Reset acts immediately on the model's state.
        if (!rst) begin
            m_hold  = 0;
            m_stall = 0;
        end
        lu = vld && ld && (rd != 0) && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
        busy = 0;
        if (!rst)           begin p = 0; ie = 0; fl = 1; ee = 0; bb = 1; end
        else if (m_hold > 0) begin p = 0; ie = 0; fl = 0; ee = 0; bb = 0; busy = 1; end
        else if (br)        begin p = 1; ie = 1; fl = 1; ee = 1; bb = 1; end
        else if (lu)        begin p = 0; ie = 0; fl = 0; ee = 1; bb = 1; end
        else                begin p = 1; ie = 1; fl = 0; ee = 1; bb = 0; end
        exp_q.push_back({p, ie, fl, ee, bb, busy, CNT_W'(m_stall)});

        // Advance the model across the coming clock edge.
        if (rst) begin
            if (clr)     m_stall = 0;
            else if (!p) m_stall = (m_stall + 1) % (1 << CNT_W);
            if (m_hold > 0)
                m_hold = m_hold - 1;
            else if (!br && !lu && vld && mul && MUL_LAT > 1)
                m_hold = MUL_LAT - 1;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        logic [W-1:0] e;
        logic [5:0] got_ctl;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            got_ctl = {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_bubble, mul_busy};
            checks++;
            if (got_ctl !== e[W-1:CNT_W]) begin
                errors++;
                $display("FAIL ctl t=%0t got=%b exp=%b (pc,ifid,flush,idex,bubble,busy)",
                         $time, got_ctl, e[W-1:CNT_W]);
            end
            checks++;
            if (stall_cnt !== e[CNT_W-1:0]) begin
                errors++;
                $display("FAIL stall_cnt t=%0t got=%0d exp=%0d", $time, stall_cnt, e[CNT_W-1:0]);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        // Reset for 3 cycles, then release with no hazards.
        for (int i = 0; i < 3; i++) drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(2);

        // Load-use on rs1, then a normal advance.
        drive(1, 1, 5, 0, 1, 0, 0, 5, 1, 0, 0);
        drive(1, 1, 5, 0, 1, 0, 0, 5, 0, 0, 0);
        // Load-use on rs2.
        drive(1, 1, 1, 7, 1, 1, 0, 7, 1, 0, 0);
        // Load to x0: no stall.
        drive(1, 1, 0, 0, 1, 1, 0, 0, 1, 0, 0);
        // Source matches but not used: no stall.
        drive(1, 1, 3, 3, 0, 0, 0, 3, 1, 0, 0);
        // Branch together with a load-use hazard and a multiply.
        drive(1, 1, 5, 0, 1, 0, 1, 5, 1, 1, 0);
        idle(1);

        // Single multiply pulse, then back-to-back multiplies.
        drive(1, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        idle(5);
        for (int i = 0; i < 9; i++) drive(1, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        idle(3);

        // Clear during a stall cycle, then 15 stalls, then one more to wrap.
        drive(1, 1, 4, 0, 1, 0, 0, 4, 1, 0, 1);
        for (int i = 0; i < 16; i++) drive(1, 1, 4, 0, 1, 0, 0, 4, 1, 0, 0);
        idle(2);

        // Reset while the multiply hold is active.
        drive(1, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        idle(1);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(3);

        // Random traffic with small register indices to provoke hazards.
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(99, 0) != 0,
                  $urandom_range(3, 0) != 0,
                  $urandom_range(3, 0), $urandom_range(3, 0),
                  $urandom_range(1, 0), $urandom_range(1, 0),
                  $urandom_range(5, 0) == 0,
                  $urandom_range(3, 0),
                  $urandom_range(2, 0) == 0,
                  $urandom_range(7, 0) == 0,
                  $urandom_range(29, 0) == 0);
        end

        @(posedge clk);
        @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain got=%0d pending exp=0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
